// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for the shift-add multiply-accumulate unit.
// The master side supplies operands and accepts the product; the slave side is the multiplier.
interface shift_add_multiplier_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0]   A;
    logic [NBITS-1:0]   B;
    logic [NBITS-1:0]   C;
    logic               iValid;
    logic               iReady;
    logic               oValid;
    logic               oReady;
    logic [2*NBITS-1:0] product;

    modport master (
        output A, B, C, iValid, oReady,
        input  iReady, oValid, product
    );

    modport slave (
        input  A, B, C, iValid, oReady,
        output iReady, oValid, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential multiply-accumulate: product = A*B + C, one multiplier bit per cycle.
// The accumulator is seeded with C, so the result is exactly quotient*divisor + remainder
// when fed with divider outputs. One operation in flight; fixed NBITS-cycle latency.
module shift_add_multiplier #(
    parameter int NBITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state;
    logic [NBITS-1:0]   a_reg;
    logic [NBITS-1:0]   b_reg;
    logic [2*NBITS-1:0] acc;
    logic [CW-1:0]      count;
    logic               ready_reg;
    logic               valid_reg;
    logic [2*NBITS-1:0] product_reg;

    logic [2*NBITS-1:0] shifted;
    logic [2*NBITS-1:0] add_term;
    logic [2*NBITS-1:0] acc_next;

    assign bus.iReady  = ready_reg;
    assign bus.oValid  = valid_reg;
    assign bus.product = product_reg;

    // Partial product for the current multiplier bit, added only when that bit is set.
    // The worst-case sum is 2^2N - 2^N, so the 2N-bit add never wraps.
    always_comb begin
        shifted  = '0;
        add_term = '0;
        acc_next = '0;
        shifted  = {{NBITS{1'b0}}, a_reg} << count;
        add_term = b_reg[count] ? shifted : '0;
        acc_next = acc + add_term;
    end

    // Control FSM with registered handshake outputs; reset discards any operation in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            acc         <= '0;
            count       <= '0;
            ready_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iValid && ready_reg) begin
                        a_reg     <= bus.A;
                        b_reg     <= bus.B;
                        acc       <= {{NBITS{1'b0}}, bus.C};
                        count     <= '0;
                        ready_reg <= 1'b0;
                        state     <= CALC;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (count == LAST_BIT) begin
                        product_reg <= acc_next;
                        valid_reg   <= 1'b1;
                        state       <= SEND;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                SEND: begin
                    if (bus.oReady) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready_reg <= 1'b0;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed testbench for shift_add_multiplier (NBITS=8 main instance, NBITS=16 wide instance).
module tb_shift_add_multiplier;
    logic clock = 1'b0;
    logic reset;

    int tests    = 0;
    int failures = 0;

    // Free-running clock, period 10
    always #5 clock = ~clock;

    shift_add_multiplier_if #(.NBITS(8))  bus8 ();
    shift_add_multiplier_if #(.NBITS(16)) bus16 ();

    shift_add_multiplier #(.NBITS(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    shift_add_multiplier #(.NBITS(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16)
    );

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.iReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) begin
            tests++;
            failures++;
            $display("[TB] FAIL wait_ready: iReady=%b, required 1 within 40 cycles", bus8.iReady);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus8.A      = a;
        bus8.B      = b;
        bus8.C      = c;
        bus8.iValid = 1'b1;
        @(posedge clock);
        #1;
        bus8.iValid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus8.oValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            failures++;
            $display("[TB] FAIL wait_result: oValid never rose within 40 cycles");
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus8.A      = '0;
        bus8.B      = '0;
        bus8.C      = '0;
        bus8.iValid = 1'b0;
        bus8.oReady = 1'b0;
        bus16.A      = '0;
        bus16.B      = '0;
        bus16.C      = '0;
        bus16.iValid = 1'b0;
        bus16.oReady = 1'b0;
        #2;
        tests++;
        if (bus8.iReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_iReady: got %b, expected 0", bus8.iReady);
        end
        tests++;
        if (bus8.oValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_oValid: got %b, expected 0", bus8.oValid);
        end
        tests++;
        if (bus8.product !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_product: got %0d, expected 0", bus8.product);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        tests++;
        if (bus8.iReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_iReady: got %b, expected 0 before first edge", bus8.iReady);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus8.iReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_edge_iReady: got %b, expected 1", bus8.iReady);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        bus8.oReady = 1'b1;
        wait_ready(ok);
        start_op(8'd13, 8'd11, 8'd5);
        wait_result(lat);
        tests++;
        if (lat != 8) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d edges, expected 8", lat);
        end
        tests++;
        if (bus8.product !== 16'd148) begin
            failures++;
            $display("[TB] FAIL basic_product: got %0d, expected 148", bus8.product);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus8.oValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_pulse: oValid got %b, expected 0 after transfer", bus8.oValid);
        end
        tests++;
        if (bus8.iReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_iReady: got %b, expected 1 after transfer", bus8.iReady);
        end
    endtask

    task automatic test_corners();
        logic [7:0]  a_tab [3] = '{8'd255, 8'd0,   8'd200};
        logic [7:0]  b_tab [3] = '{8'd255, 8'd200, 8'd0};
        logic [7:0]  c_tab [3] = '{8'd255, 8'd77,  8'd0};
        logic [15:0] p_tab [3] = '{16'hFF00, 16'd77, 16'd0};
        bit ok;
        int lat;
        bus8.oReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready(ok);
            start_op(a_tab[i], b_tab[i], c_tab[i]);
            wait_result(lat);
            tests++;
            if (bus8.product !== p_tab[i]) begin
                failures++;
                $display("[TB] FAIL corner_product[%0d]: got %0d, expected %0d", i, bus8.product, p_tab[i]);
            end
            tests++;
            if (lat != 8) begin
                failures++;
                $display("[TB] FAIL corner_latency[%0d]: got %0d, expected 8", i, lat);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        bus8.oReady = 1'b0;
        wait_ready(ok);
        start_op(8'd6, 8'd7, 8'd0);
        wait_result(lat);
        tests++;
        if (lat != 8) begin
            failures++;
            $display("[TB] FAIL bp_latency: got %0d, expected 8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus8.A      = 8'd1;
            bus8.B      = 8'd1;
            bus8.C      = 8'd1;
            bus8.iValid = 1'b1;
            tests++;
            if (bus8.oValid !== 1'b1 || bus8.product !== 16'd42) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d]: oValid=%b product=%0d, expected 1 and 42", i, bus8.oValid, bus8.product);
            end
            tests++;
            if (bus8.iReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_iReady[%0d]: got %b, expected 0", i, bus8.iReady);
            end
            @(posedge clock);
            #1;
        end
        bus8.iValid = 1'b0;
        bus8.oReady = 1'b1;
        @(posedge clock);
        #1;
        tests++;
        if (bus8.oValid !== 1'b0 || bus8.iReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_transfer: oValid=%b iReady=%b, expected 0 and 1", bus8.oValid, bus8.iReady);
        end
        tests++;
        if (bus8.product !== 16'd42) begin
            failures++;
            $display("[TB] FAIL bp_retain: product got %0d, expected 42", bus8.product);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        bus8.oReady = 1'b1;
        wait_ready(ok);
        bus8.A      = 8'd3;
        bus8.B      = 8'd4;
        bus8.C      = 8'd1;
        bus8.iValid = 1'b1;
        @(posedge clock);
        #1;
        tests++;
        if (bus8.iReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_accept1: iReady got %b, expected 0", bus8.iReady);
        end
        bus8.A = 8'd9;
        bus8.B = 8'd9;
        bus8.C = 8'd9;
        wait_result(lat);
        tests++;
        if (lat != 8 || bus8.product !== 16'd13) begin
            failures++;
            $display("[TB] FAIL b2b_first: lat=%0d product=%0d, expected 8 and 13", lat, bus8.product);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus8.iReady !== 1'b1 || bus8.oValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_transfer: iReady=%b oValid=%b, expected 1 and 0", bus8.iReady, bus8.oValid);
        end
        @(posedge clock);
        #1;
        tests++;
        if (bus8.iReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_accept2: iReady got %b, expected 0", bus8.iReady);
        end
        bus8.iValid = 1'b0;
        wait_result(lat);
        tests++;
        if (lat != 8 || bus8.product !== 16'd90) begin
            failures++;
            $display("[TB] FAIL b2b_second: lat=%0d product=%0d, expected 8 and 90", lat, bus8.product);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        int lat;
        bus8.oReady = 1'b1;
        wait_ready(ok);
        start_op(8'd50, 8'd50, 8'd50);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if (bus8.iReady !== 1'b0 || bus8.oValid !== 1'b0 || bus8.product !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: iReady=%b oValid=%b product=%0d, expected 0/0/0", bus8.iReady, bus8.oValid, bus8.product);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            if (bus8.oValid === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_no_pulse: oValid seen=%b, expected 0", seen);
        end
        wait_ready(ok);
        start_op(8'd100, 8'd2, 8'd1);
        wait_result(lat);
        tests++;
        if (lat != 8 || bus8.product !== 16'd201) begin
            failures++;
            $display("[TB] FAIL midreset_next: lat=%0d product=%0d, expected 8 and 201", lat, bus8.product);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_wide();
        bit ok;
        int lat;
        bus16.oReady = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus16.iReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        tests++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL wide_ready: iReady=%b, expected 1 within 40 cycles", bus16.iReady);
        end
        bus16.A      = 16'hFFFF;
        bus16.B      = 16'hFFFF;
        bus16.C      = 16'hFFFF;
        bus16.iValid = 1'b1;
        @(posedge clock);
        #1;
        bus16.iValid = 1'b0;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            lat++;
            if (bus16.oValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok || lat != 16) begin
            failures++;
            $display("[TB] FAIL wide_latency: ok=%b lat=%0d, expected 16", ok, lat);
        end
        tests++;
        if (bus16.product !== 32'hFFFF0000) begin
            failures++;
            $display("[TB] FAIL wide_product: got %h, expected ffff0000", bus16.product);
        end
        @(posedge clock);
        #1;
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", tests, failures);
        $finish;
    end
endmodule
